fft_peak_scanner: RTL and testbench

Sequencer that drives peak detection over one FFT spectrum frame. On each frame-ready pulse from the FFT core it walks the spectrum BRAM bin by bin, absorbs the BRAM read latency, tracks the largest amplitude and its bin, and converts the winning bin to a frequency. It publishes one (peak_freq, peak_amp) result per frame, with a one-cycle valid strobe, to the drum-hit classifier and the spectrum display overlay.

---
 rtl/fft_peak_pkg.sv | 34 +++
 rtl/fft_peak_scanner_peak_compare.sv | 55 +++++
 rtl/fft_peak_scanner.sv | 179 +++++++++++++++++
 tb/tb_fft_peak_scanner.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_peak_pkg.sv
// Shared types, default widths and the saturating bin-to-frequency helper
// for the FFT peak scanner.
package fft_peak_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_AMP_W  = 10;
    localparam int DEF_FREQ_W = 13;

    // Full-width product bin*step, clamped to the largest value a
    // freq_w-bit output can hold.
    function automatic logic [31:0] bin_to_freq(
        input logic [31:0] bin,
        input logic [31:0] step,
        input int unsigned freq_w
    );
        logic [63:0] prod;
        logic [63:0] lim;
        prod = {32'd0, bin} * {32'd0, step};
        lim  = (64'd1 << freq_w) - 64'd1;
        if (prod > lim) begin
            return lim[31:0];
        end else begin
            return prod[31:0];
        end
    endfunction

endpackage

// File: rtl/fft_peak_scanner_peak_compare.sv
// Running-maximum tracker. The max_amp/max_bin outputs already include the
// sample presented in the current cycle, so the final winner is available in
// the same cycle as the last returning BRAM word.
module peak_compare
    import fft_peak_pkg::*;
#(
    parameter int AMP_W  = DEF_AMP_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [AMP_W-1:0]  sample_amp,
    input  logic [ADDR_W-1:0] sample_bin,
    output logic [AMP_W-1:0]  max_amp,
    output logic [ADDR_W-1:0] max_bin
);

    logic [AMP_W-1:0]  amp_r;
    logic [ADDR_W-1:0] bin_r;
    logic [AMP_W-1:0]  amp_next_s;
    logic [ADDR_W-1:0] bin_next_s;

    // Strict greater-than keeps the lowest bin on ties; clear wins over a sample.
    always_comb begin
        amp_next_s = amp_r;
        bin_next_s = bin_r;
        if (clear) begin
            amp_next_s = {AMP_W{1'b0}};
            bin_next_s = {ADDR_W{1'b0}};
        end else if (sample_valid && (sample_amp > amp_r)) begin
            amp_next_s = sample_amp;
            bin_next_s = sample_bin;
        end else begin
            amp_next_s = amp_r;
            bin_next_s = bin_r;
        end
    end

    // Hold the running maximum between samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            amp_r <= {AMP_W{1'b0}};
            bin_r <= {ADDR_W{1'b0}};
        end else begin
            amp_r <= amp_next_s;
            bin_r <= bin_next_s;
        end
    end

    assign max_amp = amp_next_s;
    assign max_bin = bin_next_s;

endmodule

// File: rtl/fft_peak_scanner.sv
// Walks one FFT spectrum frame out of BRAM, tracks the strongest bin and
// publishes its frequency and amplitude once per frame.
module fft_peak_scanner
    import fft_peak_pkg::*;
#(
    parameter int BIN_COUNT = 1024,
    parameter int FIRST_BIN = 1,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AMP_W     = DEF_AMP_W,
    parameter int FREQ_W    = DEF_FREQ_W,
    parameter int FREQ_STEP = 4,
    parameter int RD_LAT    = 2,
    parameter int MIN_AMP   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              frame_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [AMP_W-1:0]  rd_data,
    output logic              busy,
    output logic [FREQ_W-1:0] peak_freq,
    output logic [AMP_W-1:0]  peak_amp,
    output logic              peak_valid,
    output logic              frame_dropped
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BIN_COUNT - 1);
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FIRST_BIN);
    localparam logic [7:0]        DRAIN_LAST = 8'(RD_LAT - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic              rd_en_r;
    logic [7:0]        drain_cnt_r;
    logic [7:0]        drain_next_s;
    logic              clear_s;
    logic              busy_r;
    logic              peak_valid_r;
    logic              frame_dropped_r;
    logic [FREQ_W-1:0] peak_freq_r;
    logic [AMP_W-1:0]  peak_amp_r;

    logic [RD_LAT-1:0] tag_valid_r;
    logic [ADDR_W-1:0] tag_bin_r [RD_LAT];

    logic [AMP_W-1:0]  max_amp_s;
    logic [ADDR_W-1:0] max_bin_s;
    logic [FREQ_W-1:0] freq_s;

    // Next-state, next read address and drain counter for the scan sequencer.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = {ADDR_W{1'b0}};
        drain_next_s = 8'd0;
        clear_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_ready) begin
                    state_next_s = ST_SCAN;
                    addr_next_s  = START_ADDR;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (rd_addr_r == LAST_ADDR) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_SCAN;
                    addr_next_s  = rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                    drain_next_s = drain_cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; rd_en/busy are derived from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            rd_addr_r       <= {ADDR_W{1'b0}};
            rd_en_r         <= 1'b0;
            drain_cnt_r     <= 8'd0;
            busy_r          <= 1'b0;
            peak_valid_r    <= 1'b0;
            frame_dropped_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            rd_addr_r       <= addr_next_s;
            rd_en_r         <= (state_next_s == ST_SCAN);
            drain_cnt_r     <= drain_next_s;
            busy_r          <= (state_next_s != ST_IDLE);
            peak_valid_r    <= (state_next_s == ST_DONE);
            frame_dropped_r <= frame_ready && (state_r != ST_IDLE);
        end
    end

    // Tag each issued read with its bin so returning data can be attributed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                tag_bin_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            tag_valid_r[0] <= rd_en_r;
            tag_bin_r[0]   <= rd_addr_r;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_bin_r[i]   <= tag_bin_r[i-1];
            end
        end
    end

    peak_compare #(
        .AMP_W  (AMP_W),
        .ADDR_W (ADDR_W)
    ) u_peak_compare (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear_s),
        .sample_valid (tag_valid_r[RD_LAT-1]),
        .sample_amp   (rd_data),
        .sample_bin   (tag_bin_r[RD_LAT-1]),
        .max_amp      (max_amp_s),
        .max_bin      (max_bin_s)
    );

    // Frequency of the winning bin, forced to zero when the peak is too weak.
    always_comb begin
        freq_s = {FREQ_W{1'b0}};
        if (max_amp_s < AMP_W'(MIN_AMP)) begin
            freq_s = {FREQ_W{1'b0}};
        end else begin
            freq_s = FREQ_W'(bin_to_freq(32'(max_bin_s), 32'(FREQ_STEP), FREQ_W));
        end
    end

    // Result registers load on the edge into DONE and hold between frames.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            peak_freq_r <= {FREQ_W{1'b0}};
            peak_amp_r  <= {AMP_W{1'b0}};
        end else if (state_next_s == ST_DONE) begin
            peak_freq_r <= freq_s;
            peak_amp_r  <= max_amp_s;
        end else begin
            peak_freq_r <= peak_freq_r;
            peak_amp_r  <= peak_amp_r;
        end
    end

    assign rd_en         = rd_en_r;
    assign rd_addr       = rd_addr_r;
    assign busy          = busy_r;
    assign peak_freq     = peak_freq_r;
    assign peak_amp      = peak_amp_r;
    assign peak_valid    = peak_valid_r;
    assign frame_dropped = frame_dropped_r;

endmodule

// File: tb/tb_fft_peak_scanner.sv
// Self-checking bench for fft_peak_scanner: BRAM model with read latency,
// expected results queued at frame start and compared on peak_valid.
module tb_fft_peak_scanner;

    localparam int BINS    = 1024;
    localparam int FIRST   = 1;
    localparam int LAT     = 2;
    localparam int LATENCY = BINS - FIRST + LAT + 1;

    typedef struct {
        logic [12:0] freq;
        logic [9:0]  amp;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_ready = 1'b0;
    logic        frame_ready2 = 1'b0;
    logic        rd_en, rd_en2;
    logic [9:0]  rd_addr, rd_addr2;
    logic [9:0]  rd_data, rd_data2;
    logic        busy, busy2;
    logic [12:0] peak_freq, peak_freq2;
    logic [9:0]  peak_amp, peak_amp2;
    logic        peak_valid, peak_valid2;
    logic        frame_dropped, frame_dropped2;

    logic [9:0]  mem [BINS];
    logic [9:0]  p1 = 10'd0, p2 = 10'd0, q1 = 10'd0, q2 = 10'd0;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int drop_cnt = 0;
    exp_t exp_q[$];

    fft_peak_scanner dut (
        .clock(clock), .reset_n(reset_n), .frame_ready(frame_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .peak_freq(peak_freq), .peak_amp(peak_amp), .peak_valid(peak_valid),
        .frame_dropped(frame_dropped)
    );

    fft_peak_scanner #(.FREQ_STEP(16)) dut2 (
        .clock(clock), .reset_n(reset_n), .frame_ready(frame_ready2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2),
        .peak_freq(peak_freq2), .peak_amp(peak_amp2), .peak_valid(peak_valid2),
        .frame_dropped(frame_dropped2)
    );

    initial forever #5 clock = ~clock;

    // BRAM model: data appears LAT cycles after rd_en; junk when not enabled.
    always @(posedge clock) begin
        p1 <= rd_en ? mem[rd_addr] : 10'h3FF;
        p2 <= p1;
        q1 <= rd_en2 ? mem[rd_addr2] : 10'h3FF;
        q2 <= q1;
    end
    assign rd_data  = p2;
    assign rd_data2 = q2;

    // Strobe counters for the main instance.
    always @(negedge clock) begin
        if (peak_valid)    valid_cnt <= valid_cnt + 1;
        if (frame_dropped) drop_cnt  <= drop_cnt + 1;
    end

    function automatic exp_t model(input int step);
        exp_t e;
        int best = 0;
        int bin = 0;
        int f;
        for (int b = FIRST; b < BINS; b++) begin
            if (int'(mem[b]) > best) begin
                best = int'(mem[b]);
                bin = b;
            end
        end
        f = bin * step;
        if (f > 8191) f = 8191;
        if (best < 16) f = 0;
        e.freq = 13'(f);
        e.amp  = 10'(best);
        return e;
    endfunction

    task automatic fill(input logic [9:0] v);
        for (int b = 0; b < BINS; b++) mem[b] = v;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clock);
        #1;
    endtask

    // One frame on the main instance, optional extra frame_ready at cycles c1/c2.
    task automatic run_frame(input string name, input int c1, input int c2);
        exp_t e;
        int lat;
        bit seen;
        exp_q.push_back(model(4));
        @(posedge clock); #1 frame_ready = 1'b1;
        @(posedge clock); #1 frame_ready = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 1200) begin
            frame_ready = (lat == c1) || (lat == c2);
            @(negedge clock);
            if (lat == 1) begin
                checks++;
                if (rd_en !== 1'b1 || rd_addr !== 10'd1 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s scan_start: en=%b addr=%0d busy=%b want 1/1/1", name, rd_en, rd_addr, busy);
                end
            end
            if (lat == BINS - FIRST) begin
                checks++;
                if (rd_en !== 1'b1 || rd_addr !== 10'd1023) begin
                    failures++;
                    $display("FAIL %s last_issue: en=%b addr=%0d want 1/1023", name, rd_en, rd_addr);
                end
            end
            if (lat == BINS - FIRST + 1) begin
                checks++;
                if (rd_en !== 1'b0 || rd_addr !== 10'd0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s drain: en=%b addr=%0d busy=%b want 0/0/1", name, rd_en, rd_addr, busy);
                end
            end
            if (peak_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clock); #1;
                lat++;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout: no peak_valid after %0d cycles, want %0d", name, lat, LATENCY);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (lat != LATENCY) begin
                failures++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, LATENCY);
            end
            checks++;
            if (peak_freq !== e.freq) begin
                failures++;
                $display("FAIL %s peak_freq: got %0d want %0d", name, peak_freq, e.freq);
            end
            checks++;
            if (peak_amp !== e.amp) begin
                failures++;
                $display("FAIL %s peak_amp: got %0d want %0d", name, peak_amp, e.amp);
            end
        end
        if (frame_ready) begin
            @(posedge clock); #1 frame_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cycles(3);
        @(negedge clock);
        checks++;
        if ({rd_en, rd_addr, busy, peak_freq, peak_amp, peak_valid, frame_dropped} !== 37'd0) begin
            failures++;
            $display("FAIL reset_values: en=%b addr=%0d busy=%b f=%0d a=%0d v=%b d=%b want all 0",
                     rd_en, rd_addr, busy, peak_freq, peak_amp, peak_valid, frame_dropped);
        end
        checks++;
        if ({rd_en2, busy2, peak_freq2, peak_valid2} !== 16'd0) begin
            failures++;
            $display("FAIL reset_values2: en=%b busy=%b f=%0d v=%b want all 0", rd_en2, busy2, peak_freq2, peak_valid2);
        end
        @(posedge clock); #1 reset_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_single_peak();
        fill(10'd5);
        mem[100] = 10'd700;
        run_frame("single", 0, 0);
        wait_cycles(3);
    endtask

    task automatic test_tie_dc();
        fill(10'd5);
        mem[0]  = 10'd1023;
        mem[50] = 10'd600;
        mem[80] = 10'd600;
        run_frame("tie_dc", 0, 0);
        wait_cycles(3);
    endtask

    task automatic test_threshold();
        int v0;
        fill(10'd10);
        v0 = valid_cnt;
        run_frame("threshold", 0, 0);
        wait_cycles(5);
        checks++;
        if (valid_cnt != v0 + 1) begin
            failures++;
            $display("FAIL threshold_valid_count: got %0d want 1", valid_cnt - v0);
        end
    endtask

    task automatic test_collision();
        int v0, d0;
        fill(10'd5);
        mem[700] = 10'd900;
        v0 = valid_cnt;
        d0 = drop_cnt;
        run_frame("collision", 500, LATENCY);
        wait_cycles(40);
        checks++;
        if (drop_cnt - d0 != 2) begin
            failures++;
            $display("FAIL collision_drops: got %0d want 2", drop_cnt - d0);
        end
        checks++;
        if (valid_cnt - v0 != 1) begin
            failures++;
            $display("FAIL collision_valids: got %0d want 1", valid_cnt - v0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL collision_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int v0, d0;
        fill(10'd5);
        mem[10] = 10'd300;
        v0 = valid_cnt;
        d0 = drop_cnt;
        run_frame("b2b_first", 0, 0);
        mem[20] = 10'd400;
        run_frame("b2b_second", 0, 0);
        wait_cycles(5);
        checks++;
        if (valid_cnt - v0 != 2 || drop_cnt != d0) begin
            failures++;
            $display("FAIL back_to_back: valids=%0d drops=%0d want 2/0", valid_cnt - v0, drop_cnt - d0);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        int lat;
        bit seen;
        fill(10'd5);
        mem[1000] = 10'd900;
        e = model(16);
        @(posedge clock); #1 frame_ready2 = 1'b1;
        @(posedge clock); #1 frame_ready2 = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 1200) begin
            @(negedge clock);
            if (peak_valid2 === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clock); #1;
                lat++;
            end
        end
        checks++;
        if (!seen || lat != LATENCY) begin
            failures++;
            $display("FAIL sat_latency: seen=%b got %0d want %0d", seen, lat, LATENCY);
        end
        checks++;
        if (peak_freq2 !== e.freq || peak_amp2 !== e.amp) begin
            failures++;
            $display("FAIL sat_result: got f=%0d a=%0d want f=%0d a=%0d", peak_freq2, peak_amp2, e.freq, e.amp);
        end
        wait_cycles(3);
    endtask

    task automatic test_reset_mid_scan();
        int v0;
        fill(10'd5);
        mem[300] = 10'd800;
        v0 = valid_cnt;
        @(posedge clock); #1 frame_ready = 1'b1;
        @(posedge clock); #1 frame_ready = 1'b0;
        wait_cycles(299);
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if ({rd_en, rd_addr, busy, peak_freq, peak_amp, peak_valid, frame_dropped} !== 37'd0) begin
            failures++;
            $display("FAIL midscan_reset_values: en=%b addr=%0d busy=%b f=%0d a=%0d v=%b d=%b want all 0",
                     rd_en, rd_addr, busy, peak_freq, peak_amp, peak_valid, frame_dropped);
        end
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(1100);
        checks++;
        if (valid_cnt != v0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midscan_no_valid: valids=%0d busy=%b want 0/0", valid_cnt - v0, busy);
        end
        mem[512] = 10'd555;
        run_frame("after_reset", 0, 0);
        wait_cycles(3);
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_tie_dc();
        test_threshold();
        test_collision();
        test_back_to_back();
        test_saturation();
        test_reset_mid_scan();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
